inv_shift_rows: RTL and testbench



---
 rtl/aes_pkg.sv | 17 +
 rtl/inv_sr_bank.sv | 23 ++
 rtl/inv_shift_rows.sv | 76 +++++++
 tb/tb_inv_shift_rows.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and the inverse ShiftRows byte-index map.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned AES_BLK_LEN = 16;

    // out[r][c] = in[r][(c-r) mod 4]; index k = 4*c + r, so the column field wraps in 2 bits.
    function automatic logic [3:0] inv_sr_src(input logic [3:0] j);
        logic [1:0] r;
        logic [1:0] c;
        r = j[1:0];
        c = j[3:2];
        return {2'(c - r), r};
    endfunction

endpackage

// File: rtl/inv_sr_bank.sv
// 16x8 register file: one synchronous write port, one combinational read port.
module inv_sr_bank
    import aes_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [3:0] i_waddr,
    input  byte_t      i_wdata,
    input  logic [3:0] i_raddr,
    output byte_t      o_rdata
);

    byte_t r_mem [AES_BLK_LEN];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inv_shift_rows.sv
// Byte-serial AES inverse ShiftRows with ping-pong banks and 16-cycle latency.
// Optional `start` output enabled by defining INV_SHIFT_ROWS_START_EN.
module inv_shift_rows
    import aes_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] inbyte,
    output logic [7:0] outbyte,
    output logic       ready
`ifdef INV_SHIFT_ROWS_START_EN
    ,
    output logic       start
`endif
);

    logic [3:0] r_wcnt;
    logic       r_bsel;
    logic       r_filled;
    logic [3:0] w_raddr;
    byte_t      w_rd0;
    byte_t      w_rd1;
    byte_t      w_rd;

    // Read and write share one counter: the read bank holds the previous block.
    assign w_raddr = inv_sr_src(r_wcnt);
    assign w_rd    = r_bsel ? w_rd0 : w_rd1;

    inv_sr_bank u_bank0 (
        .i_clk   (clock),
        .i_we    (~r_bsel),
        .i_waddr (r_wcnt),
        .i_wdata (inbyte),
        .i_raddr (w_raddr),
        .o_rdata (w_rd0)
    );

    inv_sr_bank u_bank1 (
        .i_clk   (clock),
        .i_we    (r_bsel),
        .i_waddr (r_wcnt),
        .i_wdata (inbyte),
        .i_raddr (w_raddr),
        .o_rdata (w_rd1)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt   <= '0;
            r_bsel   <= 1'b0;
            r_filled <= 1'b0;
            outbyte  <= '0;
            ready    <= 1'b0;
        end else begin
            r_wcnt <= r_wcnt + 4'd1;
            if (r_wcnt == 4'hf) begin
                r_bsel   <= ~r_bsel;
                r_filled <= 1'b1;
            end
            // Uninitialised bank contents never reach the output before the first block.
            outbyte <= r_filled ? w_rd : '0;
            ready   <= r_filled;
        end
    end

`ifdef INV_SHIFT_ROWS_START_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start <= 1'b0;
        end else begin
            start <= r_filled && (r_wcnt == 4'd0);
        end
    end
`endif

endmodule

// File: tb/tb_inv_shift_rows.sv
// Scoreboard bench for inv_shift_rows: directed FIPS-197 and index-map blocks.
module tb_inv_shift_rows;

    logic       clock;
    logic       reset_n;
    logic [7:0] inbyte;
    logic [7:0] outbyte;
    logic       ready;
`ifdef INV_SHIFT_ROWS_START_EN
    logic       start;
`endif

    inv_shift_rows dut (
        .clock   (clock),
        .reset_n (reset_n),
        .inbyte  (inbyte),
        .outbyte (outbyte),
        .ready   (ready)
`ifdef INV_SHIFT_ROWS_START_EN
        ,
        .start   (start)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         edges  = 0;
    bit         mon_en = 1'b1;

    logic [7:0] R1_IN  [16] = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,
                                8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
    logic [7:0] R1_OUT [16] = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,
                                8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
    logic [7:0] R2_IN  [16] = '{8'h49,8'hdb,8'h87,8'h3b,8'h45,8'h39,8'h53,8'h89,
                                8'h7f,8'h02,8'hd2,8'hf1,8'h77,8'hde,8'h96,8'h1a};
    logic [7:0] R2_OUT [16] = '{8'h49,8'hde,8'hd2,8'h89,8'h45,8'hdb,8'h96,8'hf1,
                                8'h7f,8'h39,8'h87,8'h1a,8'h77,8'h02,8'h53,8'h3b};
    logic [7:0] MAP_IN [16] = '{8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,
                                8'h08,8'h09,8'h0a,8'h0b,8'h0c,8'h0d,8'h0e,8'h0f};
    logic [7:0] MAP_OUT[16] = '{8'h00,8'h0d,8'h0a,8'h07,8'h04,8'h01,8'h0e,8'h0b,
                                8'h08,8'h05,8'h02,8'h0f,8'h0c,8'h09,8'h06,8'h03};

    // Posedges seen since reset release; edge index of the latest edge is edges-1.
    always @(posedge clock) begin
        if (!reset_n) edges = 0;
        else          edges = edges + 1;
    end

    always @(negedge clock) begin
        logic       rdy_exp;
        logic [7:0] e;
        rdy_exp = reset_n && (edges >= 17);
        if (!reset_n) begin
            checks = checks + 1;
            if (outbyte !== 8'h00) begin
                errors = errors + 1;
                $display("FAIL reset_outbyte: got %02h want 00", outbyte);
            end
        end
        checks = checks + 1;
        if (ready !== rdy_exp) begin
            errors = errors + 1;
            $display("FAIL ready edge%0d: got %b want %b", edges - 1, ready, rdy_exp);
        end
`ifdef INV_SHIFT_ROWS_START_EN
        checks = checks + 1;
        if (start !== (rdy_exp && ((edges - 1) % 16 == 0))) begin
            errors = errors + 1;
            $display("FAIL start edge%0d: got %b want %b", edges - 1, start,
                     rdy_exp && ((edges - 1) % 16 == 0));
        end
`endif
        if (ready === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (outbyte !== e) begin
                    errors = errors + 1;
                    $display("FAIL data edge%0d: got %02h want %02h", edges - 1, outbyte, e);
                end
            end else if (mon_en) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_output edge%0d: got %02h with empty scoreboard",
                         edges - 1, outbyte);
            end
        end
    end

    task automatic send_block(input logic [7:0] din[16], input logic [7:0] dexp[16]);
        for (int i = 0; i < 16; i++) exp_q.push_back(dexp[i]);
        for (int i = 0; i < 16; i++) begin
            inbyte = din[i];
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        bit drained;
        reset_n = 1'b0;
        inbyte  = 8'h00;
        repeat (3) begin
            @(posedge clock);
            #1;
            inbyte = 8'($urandom);
        end
        reset_n = 1'b1;

        send_block(R1_IN, R1_OUT);
        send_block(R2_IN, R2_OUT);
        send_block(MAP_IN, MAP_OUT);

        // Seven bytes of a new block, then reset drops it and the pending map output.
        for (int i = 0; i < 7; i++) begin
            inbyte = R2_IN[i];
            @(posedge clock);
            #1;
        end
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(posedge clock);
            #1;
            inbyte = 8'($urandom);
        end
        reset_n = 1'b1;
        send_block(R1_IN, R1_OUT);

        drained = 1'b0;
        inbyte  = 8'h00;
        for (int i = 0; i < 40 && !drained; i++) begin
            @(posedge clock);
            if (exp_q.size() == 0) drained = 1'b1;
        end
        mon_en = 1'b0;
        checks = checks + 1;
        if (!drained) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d bytes outstanding want 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
